// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key controller.
// States, ALU op codes, key codes and operand limits live here.
package calc_pkg;

  localparam int VAL_W      = 14;
  localparam int CNT_W      = 3;
  localparam int MAX_DIGITS = 4;
  localparam int MAX_VAL    = 9999;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    WAIT_ALU = 3'd2,
    DRAIN    = 3'd3,
    SHOW     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  function automatic logic is_digit(
    input logic [3:0] k
  );
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(
    input logic [3:0] k
  );
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic alu_op_t key_to_op(
    input logic [3:0] k
  );
    alu_op_t op;
    case (k)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: shifts in digits up to a fixed count,
// and can be cleared or loaded with a full value.
module calc_digit_acc
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [VAL_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_load_cnt,
  input  logic             i_dig,
  input  logic [3:0]       i_digit,
  output logic [VAL_W-1:0] o_val,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DIGITS);

  logic [VAL_W-1:0] r_val;
  logic [CNT_W-1:0] r_cnt;
  logic [VAL_W-1:0] w_next;
  logic [VAL_W-1:0] w_load;
  logic             w_room;

  assign w_next = r_val * VAL_W'(10)
                + {{(VAL_W-4){1'b0}}, i_digit};
  assign w_load = (i_load_val > MAX_V) ? MAX_V
                                       : i_load_val;
  assign w_room = r_cnt < MAX_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_val <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_val <= w_load;
      r_cnt <= i_load_cnt;
    end else if (i_dig && w_room) begin
      r_val <= w_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_val = r_val;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/calc_key_ctrl.sv
// Keypad sequencer for a four-function calculator: collects operands,
// issues ALU requests, supports op chaining and abort-by-clear.
module calc_key_ctrl
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [VAL_W-1:0] alu_a,
  output logic [VAL_W-1:0] alu_b,
  input  logic             alu_done,
  input  logic [VAL_W-1:0] alu_result,
  input  logic             alu_err,
  output logic [VAL_W-1:0] disp_val,
  output logic             disp_err,
  output logic [2:0]       state_dbg
);

  state_t           r_state;
  state_t           w_nstate;
  alu_op_t          r_op;
  alu_op_t          w_op_n;
  alu_op_t          r_pend;
  alu_op_t          w_pend_n;
  alu_op_t          r_alu_op;
  logic             r_chain;
  logic             w_chain_n;
  logic             r_alu_start;
  logic [VAL_W-1:0] r_alu_a;
  logic [VAL_W-1:0] r_alu_b;
  logic             w_start;
  logic             w_clr_all;

  logic             w_a_clr;
  logic             w_a_load;
  logic [VAL_W-1:0] w_a_load_val;
  logic [CNT_W-1:0] w_a_load_cnt;
  logic             w_a_dig;
  logic [VAL_W-1:0] w_a_val;
  logic [CNT_W-1:0] w_a_cnt;
  logic             w_b_clr;
  logic             w_b_dig;
  logic [VAL_W-1:0] w_b_val;
  logic [CNT_W-1:0] w_b_cnt;
  logic             w_unused_a_cnt;

  logic             w_k_dig;
  logic             w_k_op;
  logic             w_k_clr;
  logic             w_k_eq;
  logic [VAL_W-1:0] w_disp;

  assign w_k_dig = key_valid && is_digit(key_code);
  assign w_k_op  = key_valid && is_op(key_code);
  assign w_k_clr = key_valid && (key_code == KEY_CLR);
  assign w_k_eq  = key_valid && (key_code == KEY_EQ);

  assign w_unused_a_cnt = &{1'b0, w_a_cnt};

  calc_digit_acc u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_a_clr),
    .i_load     (w_a_load),
    .i_load_val (w_a_load_val),
    .i_load_cnt (w_a_load_cnt),
    .i_dig      (w_a_dig),
    .i_digit    (key_code),
    .o_val      (w_a_val),
    .o_cnt      (w_a_cnt)
  );

  calc_digit_acc u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_b_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_load_cnt ('0),
    .i_dig      (w_b_dig),
    .i_digit    (key_code),
    .o_val      (w_b_val),
    .o_cnt      (w_b_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ENTER_A;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate     = r_state;
    w_op_n       = r_op;
    w_pend_n     = r_pend;
    w_chain_n    = r_chain;
    w_start      = 1'b0;
    w_clr_all    = 1'b0;
    w_a_clr      = 1'b0;
    w_a_load     = 1'b0;
    w_a_load_val = alu_result;
    w_a_load_cnt = '0;
    w_a_dig      = 1'b0;
    w_b_clr      = 1'b0;
    w_b_dig      = 1'b0;
    unique case (r_state)
      ENTER_A: begin
        unique case (1'b1)
          w_k_clr: w_clr_all = 1'b1;
          w_k_dig: w_a_dig   = 1'b1;
          w_k_op: begin
            w_op_n   = key_to_op(key_code);
            w_b_clr  = 1'b1;
            w_nstate = ENTER_B;
          end
          default: ;
        endcase
      end
      ENTER_B: begin
        unique case (1'b1)
          w_k_clr: w_clr_all = 1'b1;
          w_k_dig: w_b_dig   = 1'b1;
          w_k_op: begin
            if (w_b_cnt == '0) begin
              w_op_n = key_to_op(key_code);
            end else begin
              w_start   = 1'b1;
              w_chain_n = 1'b1;
              w_pend_n  = key_to_op(key_code);
              w_nstate  = WAIT_ALU;
            end
          end
          w_k_eq: begin
            if (w_b_cnt != '0) begin
              w_start   = 1'b1;
              w_chain_n = 1'b0;
              w_nstate  = WAIT_ALU;
            end
          end
          default: ;
        endcase
      end
      WAIT_ALU: begin
        // A done arriving with the clear has nothing left to drain
        if (w_k_clr) begin
          if (alu_done) w_clr_all = 1'b1;
          else          w_nstate  = DRAIN;
        end else if (alu_done) begin
          if (alu_err) begin
            w_nstate = ERROR;
          end else begin
            w_a_load = 1'b1;
            if (r_chain) begin
              w_op_n    = r_pend;
              w_b_clr   = 1'b1;
              w_chain_n = 1'b0;
              w_nstate  = ENTER_B;
            end else begin
              w_nstate = SHOW;
            end
          end
        end
      end
      DRAIN: begin
        if (w_k_clr || alu_done) w_clr_all = 1'b1;
      end
      SHOW: begin
        unique case (1'b1)
          w_k_clr: w_clr_all = 1'b1;
          w_k_dig: begin
            w_a_load     = 1'b1;
            w_a_load_val = {{(VAL_W-4){1'b0}}, key_code};
            w_a_load_cnt = CNT_W'(1);
            w_b_clr      = 1'b1;
            w_nstate     = ENTER_A;
          end
          w_k_op: begin
            w_op_n   = key_to_op(key_code);
            w_b_clr  = 1'b1;
            w_nstate = ENTER_B;
          end
          default: ;
        endcase
      end
      ERROR: begin
        if (w_k_clr) w_clr_all = 1'b1;
      end
      default: w_nstate = ENTER_A;
    endcase
    if (w_clr_all) begin
      w_a_clr   = 1'b1;
      w_a_load  = 1'b0;
      w_b_clr   = 1'b1;
      w_chain_n = 1'b0;
      w_op_n    = OP_ADD;
      w_nstate  = ENTER_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= OP_ADD;
      r_pend      <= OP_ADD;
      r_chain     <= 1'b0;
      r_alu_start <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= OP_ADD;
    end else begin
      r_op        <= w_op_n;
      r_pend      <= w_pend_n;
      r_chain     <= w_chain_n;
      r_alu_start <= w_start;
      if (w_start) begin
        r_alu_a  <= w_a_val;
        r_alu_b  <= w_b_val;
        r_alu_op <= r_op;
      end
    end
  end

  always_comb begin
    w_disp = '0;
    unique case (r_state)
      ENTER_A,
      SHOW,
      WAIT_ALU: w_disp = w_a_val;
      ENTER_B:  w_disp = (w_b_cnt != '0) ? w_b_val : w_a_val;
      default:  w_disp = '0;
    endcase
  end

  assign alu_start = r_alu_start;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign disp_val  = w_disp;
  assign disp_err  = (r_state == ERROR);
  assign state_dbg = r_state;

endmodule
